// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-NUM_OUT stream demultiplexer.
// Each input beat is steered to the output port named by I_SEL. Every port has
// a one-entry holding register with VALID/READY flow control. Beats addressed
// to a port index >= NUM_OUT are discarded and reported on ERR/DROP_CNT.
//
// Ports:
//   CLK       rising-edge clock
//   RSTN      synchronous active-low reset
//   I_VALID   input beat valid
//   I_READY   input beat accepted when I_VALID & I_READY
//   I_DATA    input beat data (DATA_W)
//   I_SEL     destination port index (SEL_W), sampled with the beat
//   O_VALID   per-port valid, bit k = port k
//   O_READY   per-port ready
//   O_DATA    port k occupies bits [k*DATA_W +: DATA_W]
//   ERR       one-cycle pulse per dropped beat
//   DROP_CNT  dropped-beat count, saturating at 255
//
// Build option: define DEMUX_SKID_EN to insert a 2-entry input skid stage that
// makes I_READY a pure flop output (latency 2 instead of 1).
module demux_stream #(
    parameter int DATA_W  = 8,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic                      I_VALID,
    output logic                      I_READY,
    input  logic [DATA_W-1:0]         I_DATA,
    input  logic [SEL_W-1:0]          I_SEL,
    output logic [NUM_OUT-1:0]        O_VALID,
    input  logic [NUM_OUT-1:0]        O_READY,
    output logic [NUM_OUT*DATA_W-1:0] O_DATA,
    output logic                      ERR,
    output logic [7:0]                DROP_CNT
);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Beat presented to the steering logic (head of the input side)
    logic [DATA_W-1:0] hd_data_p0;
    logic [SEL_W-1:0]  hd_sel_p0;
    logic              hd_take;
    logic              hd_free;
    logic              hd_in_range;

    // hd_free: target slot is empty or drains this edge. Out-of-range targets
    // are always free so the beat can be discarded.
    always_comb begin
        hd_free     = 1'b1;
        hd_in_range = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (hd_sel_p0 == SEL_W'(k)) begin
                hd_free     = ~O_VALID[k] | O_READY[k];
                hd_in_range = 1'b1;
            end
        end
    end

`ifdef DEMUX_SKID_EN
    // Two-entry FIFO: main is the head, skid holds the overflow beat.
    logic              m_vld_p0, s_vld_p0, rdy_q;
    logic              m_vld_n, s_vld_n;
    logic [DATA_W-1:0] m_data_p0, s_data_p0;
    logic [SEL_W-1:0]  m_sel_p0, s_sel_p0;
    logic              push;

    assign hd_data_p0 = m_data_p0;
    assign hd_sel_p0  = m_sel_p0;
    assign hd_take    = m_vld_p0 & hd_free;
    assign I_READY    = rdy_q;
    assign push       = I_VALID & rdy_q;

    always_comb begin
        m_vld_n = m_vld_p0;
        s_vld_n = s_vld_p0;
        if (hd_take) begin
            m_vld_n = s_vld_p0 | push;
            s_vld_n = 1'b0;
        end else if (!m_vld_p0) begin
            m_vld_n = push;
        end else if (push) begin
            s_vld_n = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            m_vld_p0 <= 1'b0;
            s_vld_p0 <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            m_vld_p0 <= m_vld_n;
            s_vld_p0 <= s_vld_n;
            rdy_q    <= ~s_vld_n;
        end
    end

    // Skid entry always refills main first, which keeps input order.
    always_ff @(posedge CLK) begin
        if (hd_take && s_vld_p0) begin
            m_data_p0 <= s_data_p0;
            m_sel_p0  <= s_sel_p0;
        end else if (push && (hd_take || !m_vld_p0)) begin
            m_data_p0 <= I_DATA;
            m_sel_p0  <= I_SEL;
        end
        if (push && m_vld_p0 && !hd_take) begin
            s_data_p0 <= I_DATA;
            s_sel_p0  <= I_SEL;
        end
    end
`else
    logic rstn_q;

    always_ff @(posedge CLK) begin
        rstn_q <= RSTN;
    end

    assign hd_data_p0 = I_DATA;
    assign hd_sel_p0  = I_SEL;
    assign I_READY    = RSTN & rstn_q & hd_free;
    assign hd_take    = I_VALID & I_READY;
`endif

    // Output slots: load on accept (replaces a draining beat with no bubble),
    // otherwise clear when the consumer takes the beat.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            O_VALID  <= '0;
            O_DATA   <= '0;
            ERR      <= 1'b0;
            DROP_CNT <= 8'd0;
        end else begin
            ERR <= hd_take & ~hd_in_range;
            if (hd_take && !hd_in_range)
                DROP_CNT <= sat_inc(DROP_CNT);
            for (int k = 0; k < NUM_OUT; k++) begin
                if (hd_take && hd_sel_p0 == SEL_W'(k)) begin
                    O_VALID[k]                   <= 1'b1;
                    O_DATA[k*DATA_W +: DATA_W] <= hd_data_p0;
                end else if (O_READY[k]) begin
                    O_VALID[k] <= 1'b0;
                end
            end
        end
    end

endmodule
